// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with per-frame runtime configuration and CTS flow control
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic                    uart_cts_n,
  input  logic [12:0]             UART_CONFIG_DELAY_FRAMES,
  input  logic [4:0]              UART_CONFIG_DATABITS,
  input  logic [1:0]              UART_CONFIG_PARITY,
  input  logic [1:0]              UART_CONFIG_STOPBITS,
  input  logic [2:0]              UART_CONFIG_FLOWCTRL,
  output logic                    uart_txpin,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    uart_tx_busy
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] shreg, mask;
  logic [12:0] cnt, d_lat, d_in;
  logic [4:0] bit_idx, nb_lat, nb_in;
  logic [1:0] stop_lat;
  logic par_en, par_bit, push, pop, start_ok, bit_end;
  assign wr_ready = !fifo_level[AW];
  assign push = wr_valid && wr_ready;
  assign start_ok = fifo_level != '0 && (UART_CONFIG_FLOWCTRL != 3'd1 || !uart_cts_n);
  assign bit_end = cnt == d_lat - 13'd1;
  assign d_in = UART_CONFIG_DELAY_FRAMES < 13'd2 ? 13'd2 : UART_CONFIG_DELAY_FRAMES;
  assign nb_in = UART_CONFIG_DATABITS == 5'd0 ? 5'd1 :
                 UART_CONFIG_DATABITS > 5'(DATA_WIDTH) ? 5'(DATA_WIDTH) : UART_CONFIG_DATABITS;
  assign mask = DATA_WIDTH'((32'd1 << nb_in) - 32'd1);
  assign uart_tx_busy = state_q != IDLE;
  assign uart_txpin = state_q == START ? 1'b0 :
                      state_q == DATA ? shreg[0] :
                      state_q == PARITY ? par_bit : 1'b1;
  always_comb begin
    state_d = state_q;
    pop = 1'b0;
    case (state_q)
      IDLE: begin
        pop = start_ok;
        state_d = start_ok ? START : IDLE;
      end
      START: state_d = bit_end ? DATA : START;
      DATA: state_d = bit_end && bit_idx == nb_lat - 5'd1 ? (par_en ? PARITY : STOP) : DATA;
      PARITY: state_d = bit_end ? STOP : PARITY;
      STOP: if (bit_end && bit_idx == {3'b0, stop_lat}) begin
        pop = start_ok;
        state_d = start_ok ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_level <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      fifo_level <= fifo_level + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shreg <= '0;
      d_lat <= 13'd2;
      nb_lat <= 5'd1;
      stop_lat <= '0;
      par_en <= 1'b0;
      par_bit <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt <= state_q == IDLE || bit_end ? '0 : cnt + 13'd1;
      bit_idx <= !bit_end ? bit_idx : state_d == state_q ? bit_idx + 5'd1 : '0;
      if (pop) begin
        shreg <= mem[rd_ptr];
        d_lat <= d_in;
        nb_lat <= nb_in;
        stop_lat <= UART_CONFIG_STOPBITS;
        par_en <= ^UART_CONFIG_PARITY;
        par_bit <= ^(mem[rd_ptr] & mask) ^ (UART_CONFIG_PARITY == 2'd1);
      end else if (state_q == DATA && bit_end) begin
        shreg <= shreg >> 1;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  logic rst, wr_valid, wr_ready, uart_cts_n, uart_txpin, uart_tx_busy;
  logic [7:0] wr_data;
  logic [12:0] UART_CONFIG_DELAY_FRAMES;
  logic [4:0] UART_CONFIG_DATABITS;
  logic [1:0] UART_CONFIG_PARITY, UART_CONFIG_STOPBITS;
  logic [2:0] UART_CONFIG_FLOWCTRL;
  logic [2:0] fifo_level;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  uart_tx_fifo #(.DATA_WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .uart_cts_n(uart_cts_n), .UART_CONFIG_DELAY_FRAMES(UART_CONFIG_DELAY_FRAMES),
    .UART_CONFIG_DATABITS(UART_CONFIG_DATABITS), .UART_CONFIG_PARITY(UART_CONFIG_PARITY),
    .UART_CONFIG_STOPBITS(UART_CONFIG_STOPBITS), .UART_CONFIG_FLOWCTRL(UART_CONFIG_FLOWCTRL),
    .uart_txpin(uart_txpin), .fifo_level(fifo_level), .uart_tx_busy(uart_tx_busy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cfg(input int d, input int db, input int par, input int stp, input int flow);
    UART_CONFIG_DELAY_FRAMES = 13'(d);
    UART_CONFIG_DATABITS = 5'(db);
    UART_CONFIG_PARITY = 2'(par);
    UART_CONFIG_STOPBITS = 2'(stp);
    UART_CONFIG_FLOWCTRL = 3'(flow);
  endtask
  task automatic push(input logic [7:0] w);
    int t = 0;
    wr_data = w;
    wr_valid = 1'b1;
    while (!wr_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    wr_valid = 1'b0;
    chk("push_ready", 32'(t < 2000), 32'd1);
  endtask
  task automatic get_frame(input int nb, input int d, output logic [15:0] bits, output int waited, output int busy_n);
    bits = '0;
    waited = 0;
    busy_n = 0;
    while (uart_txpin === 1'b1 && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    for (int i = 0; i < nb * d; i++) begin
      if (i % d == 0) bits[i/d] = uart_txpin;
      else if (uart_txpin !== bits[i/d]) bits[i/d] = 1'bx;
      busy_n += int'(uart_tx_busy);
      @(negedge clk);
    end
  endtask
  task automatic frame(input string tag, input int nb, input int d, input logic [15:0] exp, input int max_wait);
    logic [15:0] bits;
    int waited, busy_n;
    get_frame(nb, d, bits, waited, busy_n);
    chk({tag, "_wait"}, 32'(waited < max_wait), 32'd1);
    chk({tag, "_bits"}, 32'(bits), 32'(exp));
    chk({tag, "_busy"}, 32'(busy_n), 32'(nb * d));
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1;
    wr_valid = 1'b0;
    wr_data = '0;
    uart_cts_n = 1'b1;
    cfg(4, 8, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_txpin", 32'(uart_txpin), 32'd1);
    chk("rst_ready", 32'(wr_ready), 32'd1);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_busy", 32'(uart_tx_busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    wr_data = 8'h55;
    wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    chk("t1_level1", 32'(fifo_level), 32'd1);
    chk("t1_busy0", 32'(uart_tx_busy), 32'd0);
    chk("t1_idle_line", 32'(uart_txpin), 32'd1);
    @(negedge clk);
    chk("t1_level0", 32'(fifo_level), 32'd0);
    chk("t1_start", 32'(uart_txpin), 32'd0);
    chk("t1_busy1", 32'(uart_tx_busy), 32'd1);
    frame("8n1_55", 10, 4, 16'h02AA, 1);
    chk("t1_end_busy", 32'(uart_tx_busy), 32'd0);
    chk("t1_end_line", 32'(uart_txpin), 32'd1);
    cfg(300, 8, 1, 1, 0);
    push(8'h01);
    frame("odd_01", 12, 300, 16'h0C02, 400);
    cfg(1, 8, 2, 1, 0);
    push(8'h01);
    frame("even_01", 12, 2, 16'h0E02, 10);
    cfg(2, 5, 0, 0, 0);
    push(8'hFF);
    fork
      frame("db5_ff", 7, 2, 16'h007E, 10);
      begin
        repeat (6) @(negedge clk);
        UART_CONFIG_DATABITS = 5'd0;
        UART_CONFIG_PARITY = 2'd1;
      end
    join
    UART_CONFIG_PARITY = 2'd0;
    push(8'hFF);
    frame("db0_ff", 3, 2, 16'h0006, 10);
    cfg(2, 31, 0, 0, 0);
    push(8'hFF);
    frame("db31_ff", 10, 2, 16'h03FE, 10);
    cfg(2, 8, 0, 0, 0);
    fork
      begin
        for (int k = 1; k <= 6; k++) begin
          push(8'(k * 17));
          if (k == 5) begin
            chk("full_level", 32'(fifo_level), 32'd4);
            chk("full_ready", 32'(wr_ready), 32'd0);
          end
        end
      end
      begin
        for (int k = 1; k <= 6; k++) begin
          frame("b2b", 10, 2, 16'({1'b1, 8'(k * 17), 1'b0}), k == 1 ? 10 : 1);
        end
      end
    join
    chk("b2b_end_busy", 32'(uart_tx_busy), 32'd0);
    chk("b2b_end_level", 32'(fifo_level), 32'd0);
    cfg(2, 8, 0, 0, 1);
    uart_cts_n = 1'b1;
    push(8'hA1);
    push(8'hB2);
    push(8'hC3);
    repeat (10) @(negedge clk);
    chk("cts_hold_level", 32'(fifo_level), 32'd3);
    chk("cts_hold_line", 32'(uart_txpin), 32'd1);
    chk("cts_hold_busy", 32'(uart_tx_busy), 32'd0);
    uart_cts_n = 1'b0;
    @(negedge clk);
    chk("cts_go_line", 32'(uart_txpin), 32'd0);
    chk("cts_go_level", 32'(fifo_level), 32'd2);
    fork
      frame("cts_a1", 10, 2, 16'h0342, 1);
      begin
        repeat (4) @(negedge clk);
        uart_cts_n = 1'b1;
      end
    join
    chk("cts_stop_busy", 32'(uart_tx_busy), 32'd0);
    repeat (6) @(negedge clk);
    chk("cts_stop_line", 32'(uart_txpin), 32'd1);
    chk("cts_stop_level", 32'(fifo_level), 32'd2);
    uart_cts_n = 1'b0;
    frame("cts_b2", 10, 2, 16'h0364, 3);
    frame("cts_c3", 10, 2, 16'h0386, 1);
    cfg(4, 8, 0, 0, 0);
    push(8'h0F);
    push(8'h3C);
    chk("rst_mid_start", 32'(uart_txpin), 32'd0);
    repeat (17) @(negedge clk);
    chk("rst_mid_bit3", 32'(uart_txpin), 32'd1);
    chk("rst_mid_level", 32'(fifo_level), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_line", 32'(uart_txpin), 32'd1);
    chk("rst_mid_flush", 32'(fifo_level), 32'd0);
    chk("rst_mid_busy", 32'(uart_tx_busy), 32'd0);
    chk("rst_mid_ready", 32'(wr_ready), 32'd1);
    push(8'h96);
    frame("post_rst_96", 10, 4, 16'h032C, 3);
    repeat (5) @(negedge clk);
    chk("post_rst_idle", 32'(uart_tx_busy), 32'd0);
    chk("post_rst_level", 32'(fifo_level), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
